// File: rtl/hazard_unit_p_if.sv
// Decode-side hazard bus: pipeline status in, register-enable / bubble / flush controls out.
interface hazard_unit_p_if #(
  parameter int REG_W = 4,
  parameter int OP_W  = 4,
  parameter int CNT_W = 3
);
  logic [OP_W-1:0]  ifid_opcode;
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic             ifid_uses_rs;
  logic             ifid_uses_rt;
  logic             idex_memread;
  logic             idex_regwrite;
  logic [2:0]       idex_flag_en;
  logic [REG_W-1:0] idex_rd;
  logic [REG_W-1:0] exmem_rd;
  logic             exmem_regwrite;
  logic [2:0]       condition;
  logic             branch_taken;
  logic             mem_busy;
  logic             pc_write_en;
  logic             ifid_write_en;
  logic             idex_write_en;
  logic             exmem_write_en;
  logic             memwb_write_en;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             stall_active;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ifid_opcode, ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt,
           idex_memread, idex_regwrite, idex_flag_en, idex_rd,
           exmem_rd, exmem_regwrite, condition, branch_taken, mem_busy,
    input  pc_write_en, ifid_write_en, idex_write_en, exmem_write_en,
           memwb_write_en, idex_bubble, ifid_flush, stall_active, stall_cnt
  );

  modport slave (
    input  ifid_opcode, ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt,
           idex_memread, idex_regwrite, idex_flag_en, idex_rd,
           exmem_rd, exmem_regwrite, condition, branch_taken, mem_busy,
    output pc_write_en, ifid_write_en, idex_write_en, exmem_write_en,
           memwb_write_en, idex_bubble, ifid_flush, stall_active, stall_cnt
  );
endinterface

// File: rtl/hazard_unit_p.sv
// Decode-stage hazard detector with multi-cycle stall counter and memory-busy freeze.
module hazard_unit_p #(
  parameter int             REG_W        = 4,
  parameter int             OP_W         = 4,
  parameter logic [OP_W-1:0] B_OP        = 4'b1100,
  parameter logic [OP_W-1:0] BR_OP       = 4'b1101,
  parameter int             LU_STALL     = 1,
  parameter int             FLAG_STALL   = 1,
  parameter int             BR_EX_STALL  = 2,
  parameter int             BR_MEM_STALL = 1,
  parameter int             MAX_STALL    = 4,
  parameter bit             GUARD        = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  hazard_unit_p_if.slave  hif
);
  localparam int CNT_W = $clog2(MAX_STALL + 1);
  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] STALL   = 2'd1;
  localparam logic [1:0] GUARD_S = 2'd2;

  logic [1:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, need;
  logic             lu_hit, flag_hit, brex_hit, brmem_hit, is_br;
  logic             rs_ex, rt_ex, rs_mem, stall;

  // Register 0 is hardwired, so a zero destination never matches.
  assign rs_ex  = (hif.idex_rd  != '0) && (hif.idex_rd  == hif.ifid_rs);
  assign rt_ex  = (hif.idex_rd  != '0) && (hif.idex_rd  == hif.ifid_rt);
  assign rs_mem = (hif.exmem_rd != '0) && (hif.exmem_rd == hif.ifid_rs);
  assign is_br  = (hif.ifid_opcode == BR_OP);

  assign lu_hit    = hif.idex_memread &&
                     ((hif.ifid_uses_rs && rs_ex) || (hif.ifid_uses_rt && rt_ex));
  assign flag_hit  = ((hif.ifid_opcode == B_OP) || is_br) &&
                     (hif.idex_flag_en != 3'b000) && (hif.condition != 3'b111);
  assign brex_hit  = is_br && hif.idex_regwrite && rs_ex;
  assign brmem_hit = is_br && hif.exmem_regwrite && rs_mem;

  always_comb begin
    need = '0;
    if (lu_hit    && (CNT_W'(LU_STALL)     > need)) need = CNT_W'(LU_STALL);
    if (flag_hit  && (CNT_W'(FLAG_STALL)   > need)) need = CNT_W'(FLAG_STALL);
    if (brex_hit  && (CNT_W'(BR_EX_STALL)  > need)) need = CNT_W'(BR_EX_STALL);
    if (brmem_hit && (CNT_W'(BR_MEM_STALL) > need)) need = CNT_W'(BR_MEM_STALL);
  end

  // A held STALL stays asserted through a freeze; RUN only detects when unfrozen.
  assign stall = rst_n && ((state == STALL) ||
                           ((state == RUN) && (need != '0) && !hif.mem_busy));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (!hif.mem_busy) begin
      case (state)
        RUN: if (need != '0) begin
          cnt_nx = need - CNT_W'(1);
          if (need > CNT_W'(1)) state_nx = STALL;
          else                  state_nx = GUARD ? GUARD_S : RUN;
        end
        STALL: begin
          cnt_nx = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nx = GUARD ? GUARD_S : RUN;
        end
        GUARD_S: state_nx = RUN;
        default: begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // cnt holds cycles left including the current STALL cycle; report those after it.
  always_comb begin
    hif.stall_cnt = '0;
    if (rst_n) begin
      if (state == STALL) hif.stall_cnt = cnt - CNT_W'(1);
      else if (stall)     hif.stall_cnt = need - CNT_W'(1);
    end
  end

  always_comb begin
    hif.pc_write_en    = 1'b1;
    hif.ifid_write_en  = 1'b1;
    hif.idex_write_en  = 1'b1;
    hif.exmem_write_en = 1'b1;
    hif.memwb_write_en = 1'b1;
    if (rst_n && hif.mem_busy) begin
      hif.pc_write_en    = 1'b0;
      hif.ifid_write_en  = 1'b0;
      hif.idex_write_en  = 1'b0;
      hif.exmem_write_en = 1'b0;
      hif.memwb_write_en = 1'b0;
    end else if (stall) begin
      hif.pc_write_en    = 1'b0;
      hif.ifid_write_en  = 1'b0;
    end
  end

  assign hif.idex_bubble  = stall && !hif.mem_busy;
  assign hif.ifid_flush   = rst_n && hif.branch_taken && !stall && !hif.mem_busy;
  assign hif.stall_active = stall;
endmodule

// File: tb/tb_hazard_unit_p.sv
// Directed scoreboard bench for hazard_unit_p: expectations queued at drive, checked at negedge.
module tb_hazard_unit_p;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   pc_low = 0;

  typedef struct packed {
    logic [4:0] en;
    logic       bubble;
    logic       flush;
    logic       sa;
    logic [2:0] cnt;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];

  hazard_unit_p_if #(.REG_W(4), .OP_W(4), .CNT_W(3)) hif ();

  hazard_unit_p dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hif   (hif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t o_run(input logic fl);
    o_run = '{en: 5'b11111, bubble: 1'b0, flush: fl, sa: 1'b0, cnt: 3'd0};
  endfunction

  function automatic obs_t o_stall(input logic [2:0] c);
    o_stall = '{en: 5'b00111, bubble: 1'b1, flush: 1'b0, sa: 1'b1, cnt: c};
  endfunction

  function automatic obs_t o_frz(input logic sa, input logic [2:0] c);
    o_frz = '{en: 5'b00000, bubble: 1'b0, flush: 1'b0, sa: sa, cnt: c};
  endfunction

  task automatic clear();
    hif.ifid_opcode    = 4'b0000;
    hif.ifid_rs        = 4'd0;
    hif.ifid_rt        = 4'd0;
    hif.ifid_uses_rs   = 1'b0;
    hif.ifid_uses_rt   = 1'b0;
    hif.idex_memread   = 1'b0;
    hif.idex_regwrite  = 1'b0;
    hif.idex_flag_en   = 3'b000;
    hif.idex_rd        = 4'd0;
    hif.exmem_rd       = 4'd0;
    hif.exmem_regwrite = 1'b0;
    hif.condition      = 3'b000;
    hif.branch_taken   = 1'b0;
    hif.mem_busy       = 1'b0;
  endtask

  task automatic set_lu();
    hif.idex_memread = 1'b1;
    hif.idex_rd      = 4'd3;
    hif.ifid_rs      = 4'd3;
    hif.ifid_uses_rs = 1'b1;
  endtask

  task automatic set_brex();
    hif.ifid_opcode   = 4'b1101;
    hif.ifid_rs       = 4'd5;
    hif.idex_regwrite = 1'b1;
    hif.idex_rd       = 4'd5;
  endtask

  // One cycle: queue expectation, sample at negedge, advance past the next posedge.
  task automatic step(input string tag, input obs_t e);
    obs_t  o, x;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    o.en     = {hif.pc_write_en, hif.ifid_write_en, hif.idex_write_en,
                hif.exmem_write_en, hif.memwb_write_en};
    o.bubble = hif.idex_bubble;
    o.flush  = hif.ifid_flush;
    o.sa     = hif.stall_active;
    o.cnt    = hif.stall_cnt;
    if (!o.en[4]) pc_low++;
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, o, x);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear();
    hif.branch_taken = 1'b1;
    @(posedge clk);
    #1;
    step("reset", o_run(1'b0));
    rst_n = 1'b1;
    clear();
    step("idle", o_run(1'b0));

    set_lu();
    step("lu_det", o_stall(3'd0));
    step("lu_guard", o_run(1'b0));
    step("lu_redetect", o_stall(3'd0));
    step("lu_guard2", o_run(1'b0));
    clear();
    hif.idex_memread = 1'b1; hif.idex_rd = 4'd3; hif.ifid_rs = 4'd3;
    step("lu_not_used", o_run(1'b0));
    clear();
    hif.idex_memread = 1'b1; hif.ifid_uses_rs = 1'b1;
    step("lu_reg0", o_run(1'b0));

    clear(); set_brex();
    step("brex_det", o_stall(3'd1));
    hif.branch_taken = 1'b1;
    step("brex_2nd", o_stall(3'd0));
    hif.branch_taken = 1'b0;
    step("brex_guard", o_run(1'b0));
    clear(); set_brex();
    hif.idex_rd = 4'd0; hif.ifid_rs = 4'd0;
    step("brex_reg0", o_run(1'b0));

    clear(); set_brex();
    hif.idex_flag_en = 3'b001;
    step("ovl_det", o_stall(3'd1));
    step("ovl_2nd", o_stall(3'd0));
    step("ovl_guard", o_run(1'b0));
    clear();
    hif.ifid_opcode = 4'b1101; hif.idex_flag_en = 3'b001; hif.condition = 3'b111;
    step("flag_uncond", o_run(1'b0));
    hif.ifid_opcode = 4'b1100; hif.condition = 3'b010;
    step("flag_b", o_stall(3'd0));
    step("flag_guard", o_run(1'b0));

    clear();
    hif.ifid_opcode = 4'b1101; hif.ifid_rs = 4'd7;
    hif.exmem_regwrite = 1'b1; hif.exmem_rd = 4'd7;
    step("brmem_det", o_stall(3'd0));
    step("brmem_guard", o_run(1'b0));

    clear(); set_brex();
    pc_low = 0;
    step("frz_det", o_stall(3'd1));
    hif.mem_busy = 1'b1;
    step("frz_1", o_frz(1'b1, 3'd0));
    step("frz_2", o_frz(1'b1, 3'd0));
    step("frz_3", o_frz(1'b1, 3'd0));
    hif.mem_busy = 1'b0;
    step("frz_end", o_stall(3'd0));
    step("frz_guard", o_run(1'b0));
    checks++;
    assert (pc_low == 5) else begin
      errors++;
      $error("FAIL frz_pc_low observed=%0d expected=5", pc_low);
    end

    clear(); set_lu();
    hif.mem_busy = 1'b1;
    step("frz_run", o_frz(1'b0, 3'd0));
    hif.mem_busy = 1'b0;
    step("frz_run_det", o_stall(3'd0));
    step("frz_run_guard", o_run(1'b0));

    clear();
    hif.branch_taken = 1'b1;
    step("flush", o_run(1'b1));
    set_lu();
    step("flush_lu", o_stall(3'd0));
    step("flush_guard", o_run(1'b1));
    clear();
    hif.branch_taken = 1'b1; hif.mem_busy = 1'b1;
    step("flush_busy", o_frz(1'b0, 3'd0));

    clear(); set_brex();
    step("rst_det", o_stall(3'd1));
    rst_n = 1'b0;
    step("rst_mid", o_run(1'b0));
    rst_n = 1'b1;
    step("rst_rerun", o_stall(3'd1));
    step("rst_rerun2", o_stall(3'd0));
    clear();
    step("rst_final", o_run(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
